// File: rtl/issue_scoreboard_if.sv
// Request, issue and writeback signals between the decoder, the issue scoreboard and the datapath.
// The slave modport is the scoreboard's view of the bus; master is the decoder/datapath side.
interface issue_scoreboard_if;
  logic       in_valid;
  logic [2:0] in_op;
  logic [4:0] in_rd;
  logic [4:0] in_rs1;
  logic [4:0] in_rs2;
  logic       in_ready;
  logic       issue_valid;
  logic [1:0] issue_fu;
  logic [2:0] issue_op;
  logic [4:0] issue_rd;
  logic [4:0] issue_rs1;
  logic [4:0] issue_rs2;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic [1:0] wb_fu;
  logic       illegal;
  logic       busy;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2,
    input  in_ready, issue_valid, issue_fu, issue_op, issue_rd, issue_rs1, issue_rs2,
    input  wb_valid, wb_rd, wb_fu, illegal, busy
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2,
    output in_ready, issue_valid, issue_fu, issue_op, issue_rd, issue_rs1, issue_rs2,
    output wb_valid, wb_rd, wb_fu, illegal, busy
  );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: register pending bitmap, four non-pipelined functional units
// with down-counters, and a single fixed-priority writeback port (DIV > MUL > MEM > ALU).
module issue_scoreboard #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  issue_scoreboard_if.slave sb
);
  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_MUL = 2'd1;
  localparam logic [1:0] FU_DIV = 2'd2;
  localparam logic [1:0] FU_MEM = 2'd3;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MUL   = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;

  function automatic logic [3:0] fu_lat(input logic [1:0] fu);
    case (fu)
      FU_MUL:  fu_lat = 4'(MUL_LAT);
      FU_DIV:  fu_lat = 4'(DIV_LAT);
      FU_MEM:  fu_lat = 4'(MEM_LAT);
      default: fu_lat = 4'd1;
    endcase
  endfunction

  logic [31:0]     pend_q, pend_d;
  logic [3:0]      fu_busy_q, fu_busy_d;
  logic [3:0][3:0] cnt_q, cnt_d;
  logic [3:0][4:0] fu_rd_q, fu_rd_d;
  logic            issue_valid_q, issue_valid_d;
  logic            illegal_q, illegal_d;
  logic [1:0]      issue_fu_q, issue_fu_d;
  logic [2:0]      issue_op_q, issue_op_d;
  logic [4:0]      issue_rd_q, issue_rd_d;
  logic [4:0]      issue_rs1_q, issue_rs1_d;
  logic [4:0]      issue_rs2_q, issue_rs2_d;

  logic [1:0] tgt_fu;
  logic       op_illegal;
  logic       use_rs2;
  logic       has_rd;
  logic       ready_c;
  logic       accept;
  logic [3:0] done;
  logic       gnt_valid;
  logic [1:0] gnt_fu;

  always_comb begin
    tgt_fu     = FU_ALU;
    op_illegal = 1'b0;
    use_rs2    = 1'b1;
    has_rd     = 1'b1;
    case (sb.in_op)
      OP_ADD, OP_SUB: tgt_fu = FU_ALU;
      OP_MUL:         tgt_fu = FU_MUL;
      OP_DIV:         tgt_fu = FU_DIV;
      OP_LOAD: begin
        tgt_fu  = FU_MEM;
        use_rs2 = 1'b0;
      end
      OP_STORE: begin
        tgt_fu = FU_MEM;
        has_rd = 1'b0;
      end
      default: begin
        op_illegal = 1'b1;
        use_rs2    = 1'b0;
        has_rd     = 1'b0;
      end
    endcase
  end

  // Readiness looks only at registered state, so a grant this cycle cannot unblock an op.
  always_comb begin
    if (op_illegal) begin
      ready_c = 1'b1;
    end else begin
      ready_c = !fu_busy_q[tgt_fu]
             && !pend_q[sb.in_rs1]
             && !(use_rs2 && pend_q[sb.in_rs2])
             && !(has_rd && (sb.in_rd != 5'd0) && pend_q[sb.in_rd]);
    end
  end

  assign accept = sb.in_valid && ready_c && !rst;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      done[i] = fu_busy_q[i] && (cnt_q[i] == 4'd0);
    end
    gnt_valid = |done;
    if (done[FU_DIV])      gnt_fu = FU_DIV;
    else if (done[FU_MUL]) gnt_fu = FU_MUL;
    else if (done[FU_MEM]) gnt_fu = FU_MEM;
    else                   gnt_fu = FU_ALU;
  end

  always_comb begin
    pend_d        = pend_q;
    fu_busy_d     = fu_busy_q;
    cnt_d         = cnt_q;
    fu_rd_d       = fu_rd_q;
    issue_valid_d = 1'b0;
    illegal_d     = 1'b0;
    issue_fu_d    = issue_fu_q;
    issue_op_d    = issue_op_q;
    issue_rd_d    = issue_rd_q;
    issue_rs1_d   = issue_rs1_q;
    issue_rs2_d   = issue_rs2_q;

    // A DONE unit parks at zero until it wins the writeback port.
    for (int i = 0; i < 4; i++) begin
      if (fu_busy_q[i] && (cnt_q[i] != 4'd0)) cnt_d[i] = cnt_q[i] - 4'd1;
    end

    if (gnt_valid) begin
      fu_busy_d[gnt_fu]       = 1'b0;
      pend_d[fu_rd_q[gnt_fu]] = 1'b0;
    end

    if (accept) begin
      issue_fu_d  = tgt_fu;
      issue_op_d  = sb.in_op;
      issue_rd_d  = sb.in_rd;
      issue_rs1_d = sb.in_rs1;
      issue_rs2_d = sb.in_rs2;
      if (op_illegal) begin
        illegal_d = 1'b1;
      end else begin
        issue_valid_d     = 1'b1;
        fu_busy_d[tgt_fu] = 1'b1;
        cnt_d[tgt_fu]     = fu_lat(tgt_fu);
        fu_rd_d[tgt_fu]   = has_rd ? sb.in_rd : 5'd0;
        if (has_rd) pend_d[sb.in_rd] = 1'b1;
      end
    end

    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q        <= '0;
      fu_busy_q     <= '0;
      cnt_q         <= '0;
      fu_rd_q       <= '0;
      issue_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      issue_fu_q    <= '0;
      issue_op_q    <= '0;
      issue_rd_q    <= '0;
      issue_rs1_q   <= '0;
      issue_rs2_q   <= '0;
    end else begin
      pend_q        <= pend_d;
      fu_busy_q     <= fu_busy_d;
      cnt_q         <= cnt_d;
      fu_rd_q       <= fu_rd_d;
      issue_valid_q <= issue_valid_d;
      illegal_q     <= illegal_d;
      issue_fu_q    <= issue_fu_d;
      issue_op_q    <= issue_op_d;
      issue_rd_q    <= issue_rd_d;
      issue_rs1_q   <= issue_rs1_d;
      issue_rs2_q   <= issue_rs2_d;
    end
  end

  assign sb.in_ready    = ready_c;
  assign sb.issue_valid = issue_valid_q;
  assign sb.issue_fu    = issue_fu_q;
  assign sb.issue_op    = issue_op_q;
  assign sb.issue_rd    = issue_rd_q;
  assign sb.issue_rs1   = issue_rs1_q;
  assign sb.issue_rs2   = issue_rs2_q;
  assign sb.illegal     = illegal_q;
  assign sb.wb_valid    = gnt_valid;
  assign sb.wb_fu       = gnt_valid ? gnt_fu : 2'd0;
  assign sb.wb_rd       = gnt_valid ? fu_rd_q[gnt_fu] : 5'd0;
  assign sb.busy        = (|fu_busy_q) || (|pend_q);
endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, MUL cycles from issue to result-ready (range 1..15).
REQ-002 SHALL have parameter DIV_LAT, default 8, DIV cycles from issue to result-ready (range 1..15).
REQ-003 SHALL have parameter MEM_LAT, default 2, LOAD/STORE cycles from issue to result-ready (range 1..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  decoded instruction present.
REQ-007 in_op  input  3  operation code: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LOAD, 5 STORE, 6-7 illegal.
REQ-008 in_rd / in_rs1 / in_rs2  input  5 each  register indices.
REQ-009 in_ready  output  1  instruction accepted this cycle when in_valid&&in_ready.
REQ-010 issue_valid  output  1  one-cycle issue pulse to datapath.
REQ-011 issue_fu  output  2  0 ALU, 1 MUL, 2 DIV, 3 MEM.
REQ-012 issue_op / issue_rd / issue_rs1 / issue_rs2  output  3/5/5/5  registered copy of accepted fields.
REQ-013 wb_valid  output  1  one-cycle writeback grant; wb_rd  output  5; wb_fu  output  2.
REQ-014 illegal  output  1  one-cycle pulse, accepted op was 6 or 7.
REQ-015 busy  output  1  any FU occupied or any pending bit set.

Function
REQ-016 SHALL keep a 32-bit pending bitmap; bit 0 never set.
REQ-017 Sources: ADD/SUB/MUL/DIV and STORE read rs1,rs2; LOAD reads rs1 only; destination for ADD/SUB/MUL/DIV/LOAD is rd; STORE has none.
REQ-018 in_ready SHALL be combinational from registered state only: target FU free AND no used source pending AND destination (if any, nonzero) not pending; illegal ops: in_ready=1.
REQ-019 On accept at edge T: issue_* registered, issue_valid=1 during cycle T+1; pending[rd] set from T+1 (rd!=0, not STORE); target FU occupied from T+1.
REQ-020 Illegal accept: no issue_valid, no FU, no pending change; illegal=1 during T+1.
REQ-021 Each FU non-pipelined, one instruction, own down-counter; ALU latency 1, others per parameter.
REQ-022 FU result-ready in cycle T+1+LAT (ALU: T+2); remains DONE until granted writeback.
REQ-023 Single writeback port, fixed priority DIV > MUL > MEM > ALU among DONE FUs; grant gives wb_valid=1, wb_rd, wb_fu same cycle.
REQ-024 Granted FU freed and pending[wb_rd] cleared at end of grant cycle; in_ready may rise next cycle, never in grant cycle (no same-cycle bypass).
REQ-025 STORE and rd=0 ops still take a grant; wb_rd = issue rd for rd=0 ops, 0 for STORE; no pending change.
REQ-026 Losing FUs hold DONE, no counter wrap or underflow; new op to that FU blocked until freed.
REQ-027 Only one accept per cycle; in_valid low or in_ready low: no state change from input side.
REQ-028 in_valid may drop or fields change while in_ready=0; no requirement to hold.

Reset
REQ-029 While rst=1 at an edge: pending=0, all FUs free, counters 0; outputs issue_valid, wb_valid, illegal, busy = 0, issue_*/wb_* fields = 0, in_ready evaluates to 1 next cycle.
REQ-030 Reset mid-operation discards all in-flight ops; no wb_valid for them after reset.
REQ-031 in_valid during rst=1 SHALL not be accepted.

Verification
REQ-032 ADD r3,r1,r2 accepted T0 -> issue_valid T1 fu=0, wb_valid T2 rd=3, busy low T3.
REQ-033 MUL r5 (MUL_LAT=3) at T0, then ADD r6,r5,r1 offered T1 -> in_ready=0 until wb rd=5 at T4; ADD accepted T5.
REQ-034 DIV r7 then MUL r8 back-to-back (DIV_LAT=8, MUL_LAT=3) -> MUL wb T5, DIV wb T9; second MUL blocked until T6.
REQ-035 DIV and ALU DONE same cycle -> DIV granted first, ALU granted next cycle, rd bits cleared in order.
REQ-036 in_op=7 accepted -> illegal pulse next cycle, no issue_valid, pending unchanged; ADD r0,r1,r1 -> wb_valid rd=0, pending stays 0.
REQ-037 rst=1 two cycles after DIV issue -> no later wb_valid, pending=0, busy=0, in_ready=1 after release.
